min_max_scan_ctrl: RTL and testbench

- Sequencing controller for the team's 16-bit compare datapath.
- Finds the minimum (or maximum) of a COUNT-element stream using one time-shared comparator instead of a compare tree.
- Accepts one element per cycle through a valid/ready handshake.
- Holds the winning value and its stream index behind a valid/ack result handshake for the downstream consumer.

---
 rtl/min_max_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_min_max_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/min_max_scan_ctrl.sv
// -----------------------------------------------------------------------------
// min_max_scan_ctrl
//
// Sequencing controller that finds the minimum (mode=0) or maximum (mode=1)
// of a COUNT-element unsigned stream with a single time-shared comparator.
// Elements arrive one per cycle over a valid/ready handshake; the winning
// value and its 0-based stream index are held behind a valid/ack handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      begin a scan (honoured only in IDLE)
//   mode       0 = minimum, 1 = maximum (captured when start is honoured)
//   in_data    stream element
//   in_valid   in_data is valid
//   in_ready   controller accepts in_data this cycle (SCAN)
//   res_data   winning element
//   res_idx    stream position of the winning element
//   res_valid  res_data/res_idx valid and held (DONE)
//   res_ack    consumer has taken the result
//   busy       scan in progress or result pending
// -----------------------------------------------------------------------------
module min_max_scan_ctrl #(
  parameter int WIDTH = 16,
  parameter int COUNT = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [IDXW-1:0]  res_idx,
  output logic             res_valid,
  input  logic             res_ack,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(COUNT - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  cnt;
  logic [WIDTH-1:0] best;
  logic [IDXW-1:0]  best_idx;
  logic             mode_q;

  logic accept;
  logic better;

  assign accept = (state_q == SCAN) && in_valid;
  // Strict comparison: an equal element never displaces the earlier winner.
  assign better = mode_q ? (in_data > best) : (in_data < best);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SCAN;
      SCAN:    if (accept && (cnt == LAST)) state_d = DONE;
      DONE:    if (res_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers. These are plain flops, not a memory, so they are all
  // reset: an aborted scan must leave nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      best     <= '0;
      best_idx <= '0;
      mode_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) begin
        cnt    <= '0;
        mode_q <= mode;
      end
      if (accept) begin
        // The first element seeds the comparator unconditionally.
        if (cnt == '0) begin
          best     <= in_data;
          best_idx <= '0;
        end else if (better) begin
          best     <= in_data;
          best_idx <= cnt;
        end
        if (cnt == LAST) cnt <= '0;
        else             cnt <= cnt + 1'b1;
      end
    end
  end

  // Outputs come from state or registers only; no input reaches an output
  // combinationally.
  assign in_ready  = (state_q == SCAN);
  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_data  = best;
  assign res_idx   = best_idx;

endmodule

// File: tb/tb_min_max_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_min_max_scan_ctrl
//
// Self-checking bench for min_max_scan_ctrl with COUNT=4. Inputs are driven
// and outputs sampled on the falling edge; the DUT acts on the rising edge.
// Expected results come from a reference function that finds the extreme
// value of the stream and then its first occurrence.
// -----------------------------------------------------------------------------
module tb_min_max_scan_ctrl;

  localparam int WIDTH = 16;
  localparam int COUNT = 4;
  localparam int IDXW  = 2;

  typedef logic [WIDTH-1:0] vec_t [COUNT];
  typedef int               gap_t [COUNT];

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] res_data;
  logic [IDXW-1:0]  res_idx;
  logic             res_valid;
  logic             res_ack = 1'b0;
  logic             busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  min_max_scan_ctrl #(.WIDTH(WIDTH), .COUNT(COUNT), .IDXW(IDXW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .res_data (res_data),
    .res_idx  (res_idx),
    .res_valid(res_valid),
    .res_ack  (res_ack),
    .busy     (busy)
  );

  // Reference: find the extreme value, then the lowest index holding it.
  function automatic void ref_result(input logic m, input vec_t v,
                                     output logic [WIDTH-1:0] rd,
                                     output logic [IDXW-1:0] ri);
    int ext;
    ext = v[0];
    foreach (v[i]) begin
      if (m  && int'(v[i]) > ext) ext = v[i];
      if (!m && int'(v[i]) < ext) ext = v[i];
    end
    rd = WIDTH'(ext);
    ri = '0;
    for (int i = COUNT - 1; i >= 0; i--)
      if (int'(v[i]) == ext) ri = IDXW'(i);
  endfunction

  // Runs one scan: start, then each element preceded by gap[i] stall cycles.
  // poke drives start during the stall cycles (must be ignored). Finishes
  // on the falling edge where res_valid should first be seen.
  task automatic do_scan(input string name, input logic m, input vec_t v,
                         input gap_t gap, input bit poke);
    logic [WIDTH-1:0] exp_d;
    logic [IDXW-1:0]  exp_i;
    ref_result(m, v, exp_d, exp_i);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = ~m;  // later mode changes must not affect this scan
    for (int i = 0; i < COUNT; i++) begin
      for (int g = 0; g < gap[i]; g++) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        start    = poke;
        @(negedge clk);
      end
      start = 1'b0;
      total++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || res_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s scan_state elem=%0d: ready=%b busy=%b valid=%b, need 1 1 0",
                 name, i, in_ready, busy, res_valid);
      end
      in_valid = 1'b1;
      in_data  = v[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = WIDTH'($urandom);
    total++;
    if (res_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 ||
        res_data !== exp_d || res_idx !== exp_i) begin
      bad++;
      $display("FAIL %s result: valid=%b ready=%b busy=%b data=%0d idx=%0d, need 1 0 1 %0d %0d",
               name, res_valid, in_ready, busy, res_data, res_idx, exp_d, exp_i);
    end
  endtask

  task automatic do_ack(input string name);
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s ack: valid=%b busy=%b ready=%b, need 0 0 0",
               name, res_valid, busy, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0 ||
          res_data !== '0 || res_idx !== '0) begin
        bad++;
        $display("FAIL reset cyc=%0d: ready=%b valid=%b busy=%b data=%0d idx=%0d, need all 0",
                 c, in_ready, res_valid, busy, res_data, res_idx);
      end
    end
  endtask

  task automatic test_min_scan();
    do_scan("min", 1'b0, '{16'd45, 16'd35, 16'd23, 16'd100}, '{0, 0, 0, 0}, 1'b0);
    do_ack("min");
  endtask

  task automatic test_max_stall_tie();
    do_scan("max_tie", 1'b1, '{16'd100, 16'd300, 16'd300, 16'd200}, '{0, 1, 2, 0}, 1'b0);
    do_ack("max_tie");
  endtask

  task automatic test_boundary();
    do_scan("bound_min", 1'b0, '{16'hFFFF, 16'h0, 16'h0, 16'hFFFF}, '{0, 0, 0, 0}, 1'b0);
    do_ack("bound_min");
    do_scan("bound_max", 1'b1, '{16'hFFFF, 16'h0, 16'h0, 16'hFFFF}, '{0, 0, 0, 0}, 1'b0);
    do_ack("bound_max");
  endtask

  task automatic test_ignored_controls();
    logic [WIDTH-1:0] d0;
    logic [IDXW-1:0]  i0;
    // start pokes during stalls must not restart or disturb the count.
    do_scan("ignore", 1'b1, '{16'd7, 16'd9, 16'd3, 16'd9}, '{1, 2, 1, 0}, 1'b1);
    d0 = res_data;
    i0 = res_idx;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (res_valid !== 1'b1 || res_data !== 16'd9 || res_idx !== 2'd1) begin
        bad++;
        $display("FAIL hold cyc=%0d: valid=%b data=%0d idx=%0d, need 1 9 1",
                 c, res_valid, res_data, res_idx);
      end
    end
    // start together with ack: go to IDLE and stay there.
    start   = 1'b1;
    res_ack = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    res_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || res_valid !== 1'b0 ||
          res_data !== d0 || res_idx !== i0) begin
        bad++;
        $display("FAIL start_with_ack cyc=%0d: busy=%b ready=%b valid=%b data=%0d idx=%0d, need 0 0 0 %0d %0d",
                 c, busy, in_ready, res_valid, res_data, res_idx, d0, i0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_scan();
    start = 1'b1;
    mode  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 16'd50000 + 16'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || res_valid !== 1'b0 ||
        res_data !== '0 || res_idx !== '0) begin
      bad++;
      $display("FAIL async_reset: ready=%b busy=%b valid=%b data=%0d idx=%0d, need all 0",
               in_ready, busy, res_valid, res_data, res_idx);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_scan("after_rst", 1'b0, '{16'd4, 16'd3, 16'd2, 16'd1}, '{0, 0, 0, 0}, 1'b0);
    do_ack("after_rst");
  endtask

  task automatic test_random();
    vec_t v;
    gap_t g;
    logic m;
    bit   narrow;
    for (int s = 0; s < 25; s++) begin
      narrow = ($urandom_range(0, 1) == 1);
      foreach (v[i]) v[i] = narrow ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
      foreach (g[i]) g[i] = $urandom_range(0, 2);
      m = 1'($urandom_range(0, 1));
      do_scan("random", m, v, g, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_ack("random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_min_scan();
    test_max_stall_tie();
    test_boundary();
    test_ignored_controls();
    test_reset_mid_scan();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
